// File: rtl/tmr_obi_voter.sv
// rtl/tmr_obi_voter.sv - majority voter merging three lockstep OBI requests into one bus master
// Holds a stalled winner stable until grant and broadcasts the bus response to all harts.
package tmr_obi_pkg;
    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } vote_state_t;
endpackage

module tmr_obi_voter
    import tmr_obi_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ERR_CNT_W       = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  obi_req_t [2:0]       core_req_i,
    output obi_resp_t [2:0]      core_resp_o,
    output obi_req_t             bus_req_o,
    input  obi_resp_t            bus_resp_i,
    input  logic                 clear_i,
    output logic [2:0]           mismatch_o,
    output logic                 fatal_o,
    output logic                 protocol_err_o,
    output logic [ERR_CNT_W-1:0] err_count_o
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

    vote_state_t          r_state;
    vote_state_t          w_next_state;
    obi_req_t             r_hold;
    logic [2:0]           r_count;
    logic [2:0]           r_mismatch;
    logic                 r_fatal;
    logic                 r_protocol_err;
    logic [ERR_CNT_W-1:0] r_err_count;

    obi_req_t   w_canon [3];
    obi_req_t   w_winner;
    obi_req_t   w_bus_req;
    logic [2:0] w_deviant;
    logic       w_fatal;
    logic       w_capture;
    logic       w_issue;
    logic       w_err_event;
    logic       w_eq01, w_eq02, w_eq12;

    // Idle harts compare equal regardless of the garbage on their unused fields.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_canon[k] = core_req_i[k].req ? core_req_i[k] : '0;
        end
    end

    assign w_eq01 = (w_canon[0] == w_canon[1]);
    assign w_eq02 = (w_canon[0] == w_canon[2]);
    assign w_eq12 = (w_canon[1] == w_canon[2]);

    always_comb begin
        w_winner  = '0;
        w_deviant = 3'b000;
        w_fatal   = 1'b0;
        if (w_eq01 && w_eq02) begin
            w_winner = w_canon[0];
        end else if (w_eq01) begin
            w_winner  = w_canon[0];
            w_deviant = 3'b100;
        end else if (w_eq02) begin
            w_winner  = w_canon[0];
            w_deviant = 3'b010;
        end else if (w_eq12) begin
            w_winner  = w_canon[1];
            w_deviant = 3'b001;
        end else begin
            w_fatal = 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_bus_req    = '0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_fatal && (r_count < MAX_CNT)) begin
                    w_bus_req = w_winner;
                    if (w_winner.req && !bus_resp_i.gnt) begin
                        w_next_state = S_HOLD;
                        w_capture    = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                w_bus_req     = r_hold;
                w_bus_req.req = 1'b1;
                if (bus_resp_i.gnt) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign bus_req_o   = w_bus_req;
    assign w_issue     = w_bus_req.req & bus_resp_i.gnt;
    assign w_err_event = (|w_deviant) | w_fatal;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            core_resp_o[k].gnt    = w_issue;
            core_resp_o[k].rvalid = bus_resp_i.rvalid;
            core_resp_o[k].rdata  = bus_resp_i.rdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
            r_count <= 3'd0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_hold <= w_winner;
            end
            case ({w_issue, bus_resp_i.rvalid})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   if (r_count != 3'd0) r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A divergence seen in the clear cycle survives the clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mismatch     <= 3'b000;
            r_fatal        <= 1'b0;
            r_protocol_err <= 1'b0;
            r_err_count    <= '0;
        end else if (clear_i) begin
            r_mismatch     <= w_deviant;
            r_fatal        <= w_fatal;
            r_protocol_err <= bus_resp_i.rvalid && (r_count == 3'd0);
            r_err_count    <= w_err_event ? {{(ERR_CNT_W-1){1'b0}}, 1'b1} : '0;
        end else begin
            r_mismatch     <= r_mismatch | w_deviant;
            r_fatal        <= r_fatal | w_fatal;
            r_protocol_err <= r_protocol_err | (bus_resp_i.rvalid && (r_count == 3'd0));
            if (w_err_event && (r_err_count != '1)) begin
                r_err_count <= r_err_count + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign mismatch_o     = r_mismatch;
    assign fatal_o        = r_fatal;
    assign protocol_err_o = r_protocol_err;
    assign err_count_o    = r_err_count;

endmodule

// File: tb/tb_tmr_obi_voter.sv
// tb/tb_tmr_obi_voter.sv - scoreboard bench for tmr_obi_voter
module tb_tmr_obi_voter;
    import tmr_obi_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    obi_req_t [2:0]  core_req;
    obi_resp_t [2:0] core_resp;
    obi_req_t        bus_req;
    obi_resp_t       bus_resp;
    logic            clear;
    logic [2:0]      mismatch;
    logic            fatal;
    logic            perr;
    logic [15:0]     err_count;

    int checks   = 0;
    int failures = 0;

    obi_req_t    q_req [$];
    logic [31:0] q_rdata [$];

    tmr_obi_voter #(.MAX_OUTSTANDING(2), .ERR_CNT_W(16)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .core_req_i     (core_req),
        .core_resp_o    (core_resp),
        .bus_req_o      (bus_req),
        .bus_resp_i     (bus_resp),
        .clear_i        (clear),
        .mismatch_o     (mismatch),
        .fatal_o        (fatal),
        .protocol_err_o (perr),
        .err_count_o    (err_count)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [95:0] act, logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    function automatic obi_req_t mk(logic req, logic [31:0] addr, logic we, logic [3:0] be, logic [31:0] wdata);
        obi_req_t r;
        r.req = req; r.addr = addr; r.we = we; r.be = be; r.wdata = wdata;
        return r;
    endfunction

    task automatic set_all(logic req, logic [31:0] addr, logic we, logic [3:0] be, logic [31:0] wdata);
        for (int k = 0; k < 3; k++) core_req[k] = mk(req, addr, we, be, wdata);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Monitor: compares every grant and every response against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_req.req && bus_resp.gnt) begin
                if (q_req.size() == 0) begin
                    chk("unexpected_grant", 96'(bus_req), 96'd0);
                end else begin
                    obi_req_t e;
                    e = q_req.pop_front();
                    chk("grant_req", 96'(bus_req), 96'(e));
                    chk("core_gnt", {core_resp[2].gnt, core_resp[1].gnt, core_resp[0].gnt}, 3'b111);
                end
            end
            if (bus_resp.rvalid) begin
                if (q_rdata.size() == 0) begin
                    chk("unexpected_rvalid", 96'(bus_resp.rdata), 96'd0);
                end else begin
                    logic [31:0] d;
                    d = q_rdata.pop_front();
                    for (int k = 0; k < 3; k++) begin
                        chk("rvalid_bcast", 96'(core_resp[k].rvalid), 96'd1);
                        chk("rdata_bcast", 96'(core_resp[k].rdata), 96'(d));
                    end
                end
            end
        end
    end

    task automatic check_reset_state(string tag);
        chk({tag, "_bus_req"}, 96'(bus_req), 96'd0);
        chk({tag, "_core_resp"}, 96'(core_resp), 96'd0);
        chk({tag, "_mismatch"}, 96'(mismatch), 96'd0);
        chk({tag, "_fatal"}, 96'(fatal), 96'd0);
        chk({tag, "_perr"}, 96'(perr), 96'd0);
        chk({tag, "_err_count"}, 96'(err_count), 96'd0);
        chk({tag, "_state"}, 96'(dut.r_state), 96'(S_IDLE));
        chk({tag, "_count"}, 96'(dut.r_count), 96'd0);
    endtask

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        bus_resp = '0;
        set_all(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        tick();
        tick();
        at_neg();
        check_reset_state("reset");
        tick();
        rst = 1'b0;

        // Unanimous read, granted immediately, response next cycle
        set_all(1'b1, 32'h1000, 1'b0, 4'hF, 32'h0);
        bus_resp.gnt = 1'b1;
        q_req.push_back(mk(1'b1, 32'h1000, 1'b0, 4'hF, 32'h0));
        at_neg();
        chk("t1_bus_addr", 96'(bus_req.addr), 96'h1000);
        tick();
        set_all(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        bus_resp = '0;
        bus_resp.rvalid = 1'b1;
        bus_resp.rdata = 32'hCAFE0001;
        q_rdata.push_back(32'hCAFE0001);
        at_neg();
        chk("t1_count_mid", 96'(dut.r_count), 96'd1);
        tick();
        bus_resp = '0;
        at_neg();
        chk("t1_count_end", 96'(dut.r_count), 96'd0);
        chk("t1_mismatch", 96'(mismatch), 96'd0);
        chk("t1_err_count", 96'(err_count), 96'd0);

        // Hart 1 diverges on wdata
        tick();
        set_all(1'b1, 32'h2000, 1'b1, 4'hF, 32'h1234);
        core_req[1].wdata = 32'hDEAD;
        bus_resp.gnt = 1'b1;
        q_req.push_back(mk(1'b1, 32'h2000, 1'b1, 4'hF, 32'h1234));
        at_neg();
        tick();
        set_all(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        bus_resp = '0;
        bus_resp.rvalid = 1'b1;
        bus_resp.rdata = 32'h5555;
        q_rdata.push_back(32'h5555);
        at_neg();
        chk("t2_mismatch", 96'(mismatch), 96'(3'b010));
        chk("t2_err_count", 96'(err_count), 96'd1);
        tick();
        bus_resp = '0;
        clear = 1'b1;
        at_neg();
        tick();
        clear = 1'b0;
        at_neg();
        chk("t2_mismatch_clr", 96'(mismatch), 96'd0);
        chk("t2_err_count_clr", 96'(err_count), 96'd0);
        chk("t2_count", 96'(dut.r_count), 96'd0);

        // Three-way disagreement
        tick();
        core_req[0] = mk(1'b1, 32'h10, 1'b0, 4'hF, 32'h0);
        core_req[1] = mk(1'b1, 32'h20, 1'b0, 4'hF, 32'h0);
        core_req[2] = mk(1'b1, 32'h30, 1'b0, 4'hF, 32'h0);
        bus_resp.gnt = 1'b1;
        at_neg();
        chk("t3_bus_req", 96'(bus_req.req), 96'd0);
        chk("t3_core_gnt", {core_resp[2].gnt, core_resp[1].gnt, core_resp[0].gnt}, 3'b000);
        tick();
        set_all(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        bus_resp = '0;
        at_neg();
        chk("t3_fatal", 96'(fatal), 96'd1);
        chk("t3_err_count", 96'(err_count), 96'd1);
        chk("t3_mismatch", 96'(mismatch), 96'd0);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        at_neg();
        chk("t3_fatal_clr", 96'(fatal), 96'd0);

        // Grant withheld: held request stays stable while harts move on
        tick();
        set_all(1'b1, 32'h3000, 1'b1, 4'h3, 32'hAAAA);
        at_neg();
        chk("t4_idle_addr", 96'(bus_req.addr), 96'h3000);
        chk("t4_core_gnt", {core_resp[2].gnt, core_resp[1].gnt, core_resp[0].gnt}, 3'b000);
        tick();
        set_all(1'b1, 32'h4000, 1'b1, 4'hF, 32'hBBBB);
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("t4_hold_req", 96'(bus_req.req), 96'd1);
            chk("t4_hold_addr", 96'(bus_req.addr), 96'h3000);
            chk("t4_hold_wdata", 96'(bus_req.wdata), 96'hAAAA);
            chk("t4_hold_state", 96'(dut.r_state), 96'(S_HOLD));
            tick();
        end
        bus_resp.gnt = 1'b1;
        q_req.push_back(mk(1'b1, 32'h3000, 1'b1, 4'h3, 32'hAAAA));
        at_neg();
        tick();
        set_all(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        bus_resp = '0;
        at_neg();
        chk("t4_count", 96'(dut.r_count), 96'd1);
        chk("t4_state", 96'(dut.r_state), 96'(S_IDLE));
        tick();
        bus_resp.rvalid = 1'b1;
        bus_resp.rdata = 32'h77;
        q_rdata.push_back(32'h77);
        at_neg();
        tick();
        bus_resp = '0;
        at_neg();
        chk("t4_count_end", 96'(dut.r_count), 96'd0);

        // Outstanding limit
        tick();
        set_all(1'b1, 32'h5000, 1'b0, 4'hF, 32'h0);
        bus_resp.gnt = 1'b1;
        q_req.push_back(mk(1'b1, 32'h5000, 1'b0, 4'hF, 32'h0));
        at_neg();
        tick();
        set_all(1'b1, 32'h5004, 1'b0, 4'hF, 32'h0);
        q_req.push_back(mk(1'b1, 32'h5004, 1'b0, 4'hF, 32'h0));
        at_neg();
        tick();
        set_all(1'b1, 32'h5008, 1'b0, 4'hF, 32'h0);
        for (int i = 0; i < 2; i++) begin
            at_neg();
            chk("t5_stall_req", 96'(bus_req.req), 96'd0);
            chk("t5_stall_gnt", {core_resp[2].gnt, core_resp[1].gnt, core_resp[0].gnt}, 3'b000);
            chk("t5_stall_count", 96'(dut.r_count), 96'd2);
            tick();
        end
        bus_resp.rvalid = 1'b1;
        bus_resp.rdata = 32'h11;
        q_rdata.push_back(32'h11);
        at_neg();
        chk("t5_stall_rvalid_req", 96'(bus_req.req), 96'd0);
        tick();
        bus_resp.rdata = 32'h22;
        q_rdata.push_back(32'h22);
        q_req.push_back(mk(1'b1, 32'h5008, 1'b0, 4'hF, 32'h0));
        at_neg();
        chk("t5_count_after_rvalid", 96'(dut.r_count), 96'd1);
        tick();
        set_all(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        bus_resp.gnt = 1'b0;
        bus_resp.rdata = 32'h33;
        q_rdata.push_back(32'h33);
        at_neg();
        chk("t5_count_simul", 96'(dut.r_count), 96'd1);
        tick();
        bus_resp = '0;
        at_neg();
        chk("t5_count_end", 96'(dut.r_count), 96'd0);

        // Response with nothing outstanding
        tick();
        bus_resp.rvalid = 1'b1;
        bus_resp.rdata = 32'hBEEF;
        q_rdata.push_back(32'hBEEF);
        at_neg();
        tick();
        bus_resp = '0;
        at_neg();
        chk("t6_perr", 96'(perr), 96'd1);
        chk("t6_count", 96'(dut.r_count), 96'd0);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        at_neg();
        chk("t6_perr_clr", 96'(perr), 96'd0);

        // Reset while holding
        tick();
        set_all(1'b1, 32'h6000, 1'b1, 4'hF, 32'h66);
        at_neg();
        tick();
        core_req[2].wdata = 32'h99;
        at_neg();
        chk("t7_state_hold", 96'(dut.r_state), 96'(S_HOLD));
        tick();
        at_neg();
        chk("t7_mismatch", 96'(mismatch), 96'(3'b100));
        tick();
        rst = 1'b1;
        at_neg();
        tick();
        rst = 1'b0;
        set_all(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        at_neg();
        check_reset_state("t7");

        at_neg();
        at_neg();
        chk("q_req_empty", 96'(q_req.size()), 96'd0);
        chk("q_rdata_empty", 96'(q_rdata.size()), 96'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
